// File: rtl/vector_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// vector_sequencer_pkg
// Shared types and constants for the vector_sequencer block:
//   - state_e      : scan controller state encoding (3 bits)
//   - DEF_WIDTH    : default input-vector width
//   - DEF_SETTLE   : default settle interval in cycles (legal 1..255)
//   - calc_n()     : truth-table size for a given vector width
// -----------------------------------------------------------------------------
package vector_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_SAMPLE    = 3'd2,
        ST_WAIT_STEP = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_SETTLE = 4;

    // Number of truth-table entries for a WIDTH-bit input vector.
    function automatic int calc_n(input int width);
        return 1 << width;
    endfunction

    localparam int DEF_N = calc_n(DEF_WIDTH);

endpackage

// File: rtl/vector_sequencer_settle_timer.sv
// -----------------------------------------------------------------------------
// settle_timer
// 8-bit loadable down-counter. Loading takes priority; otherwise the count
// decrements once per cycle and saturates at zero.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset (count clears to 0)
//   load   in   load `value` into the counter this cycle
//   value  in   8-bit reload value
//   zero   out  count is currently zero
// -----------------------------------------------------------------------------
module settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] value,
    output logic       zero
);

    logic [7:0] count_q;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of its inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else if (load) begin
            count_q <= value;
        end else if (count_q != 8'd0) begin
            count_q <= count_q - 8'd1;
        end
    end

    assign zero = (count_q == 8'd0);

endmodule

// File: rtl/vector_sequencer.sv
// -----------------------------------------------------------------------------
// vector_sequencer
// Scans all 2^WIDTH input vectors into a combinational block, samples its
// 1-bit result after SETTLE+1 cycles per vector, records the observed truth
// table and compares it against an expected table.
// Parameters:
//   WIDTH   input-vector width (table has N = 2^WIDTH entries)
//   SETTLE  settle cycles before each sample, legal 1..255
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   start       in   pulse; begins a scan when not busy
//   step_mode   in   1 = pause after each sample until `step`
//   step        in   pulse; advances to next vector while paused
//   expected    in   expected truth table (bit i for vector i)
//   vec_out     out  vector driven into the combinational block
//   res_in      in   combinational block result
//   busy        out  scan in progress
//   done        out  scan finished, results valid
//   pass        out  every entry matched (valid while done)
//   fail_valid  out  at least one mismatch in the current scan
//   first_fail  out  lowest mismatching vector index
//   table_out   out  observed truth table
// -----------------------------------------------------------------------------
module vector_sequencer
    import vector_sequencer_pkg::*;
#(
    parameter int  WIDTH  = DEF_WIDTH,
    parameter int  SETTLE = DEF_SETTLE,
    localparam int N      = calc_n(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic [N-1:0]     expected,
    output logic [WIDTH-1:0] vec_out,
    input  logic             res_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail_valid,
    output logic [WIDTH-1:0] first_fail,
    output logic [N-1:0]     table_out
);

    // The timer is loaded with SETTLE-1 so that, counting the load cycle and
    // the SAMPLE cycle, each vector is held SETTLE+1 cycles before sampling.
    localparam logic [7:0] SETTLE_RELOAD = 8'(SETTLE - 1);

    state_e           state_q;
    logic [WIDTH-1:0] vec_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic             fail_valid_q;
    logic [WIDTH-1:0] first_fail_q;
    logic [N-1:0]     table_q;

    logic timer_load;
    logic timer_zero;
    logic last_vec;
    logic mismatch;

    assign last_vec = (vec_q == '1);
    assign mismatch = res_in ^ expected[vec_q];

    // Reload the timer on exactly the transitions that enter SETTLE.
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        timer_load = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: timer_load = start;
            ST_SAMPLE:        timer_load = !last_vec && !step_mode;
            ST_WAIT_STEP:     timer_load = step;
            default:          timer_load = 1'b0;
        endcase
    end

    settle_timer u_settle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load),
        .value (SETTLE_RELOAD),
        .zero  (timer_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            vec_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
            table_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        table_q      <= '0;
                        fail_valid_q <= 1'b0;
                        first_fail_q <= '0;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        vec_q        <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    if (timer_zero) begin
                        state_q <= ST_SAMPLE;
                    end
                end

                ST_SAMPLE: begin
                    table_q[vec_q] <= res_in;
                    // Only the first mismatch is latched, giving the lowest
                    // failing index since vectors are scanned in order.
                    if (mismatch && !fail_valid_q) begin
                        fail_valid_q <= 1'b1;
                        first_fail_q <= vec_q;
                    end
                    if (last_vec) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= !(fail_valid_q || mismatch);
                        state_q <= ST_DONE;
                    end else if (step_mode) begin
                        state_q <= ST_WAIT_STEP;
                    end else begin
                        vec_q   <= vec_q + WIDTH'(1);
                        state_q <= ST_SETTLE;
                    end
                end

                ST_WAIT_STEP: begin
                    // step_mode is not consulted here: once parked, only a
                    // step pulse moves the scan forward.
                    if (step) begin
                        vec_q   <= vec_q + WIDTH'(1);
                        state_q <= ST_SETTLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign vec_out    = vec_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_valid = fail_valid_q;
    assign first_fail = first_fail_q;
    assign table_out  = table_q;

endmodule

// File: tb/tb_vector_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vector_sequencer
// Two sequencers: dut_a with default SETTLE=4 and dut_b with SETTLE=1. Each
// drives a behavioural AND-4 / XOR-4 block. Stimulus pushes the expected scan
// result when a start is accepted; a monitor pops and compares when done rises.
// -----------------------------------------------------------------------------
module tb_vector_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic xor_mode;

    // dut_a signals
    logic        start_a, step_mode_a, step_a, res_a;
    logic [15:0] exp_a, table_a;
    logic [3:0]  vec_a, ff_a;
    logic        busy_a, done_a, pass_a, fv_a;

    // dut_b signals
    logic        start_b, res_b;
    logic [15:0] exp_b, table_b;
    logic [3:0]  vec_b, ff_b;
    logic        busy_b, done_b, pass_b, fv_b;

    assign res_a = xor_mode ? ^vec_a : &vec_a;
    assign res_b = xor_mode ? ^vec_b : &vec_b;

    vector_sequencer dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .step_mode(step_mode_a),
        .step(step_a), .expected(exp_a), .vec_out(vec_a), .res_in(res_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .fail_valid(fv_a),
        .first_fail(ff_a), .table_out(table_a)
    );

    vector_sequencer #(.SETTLE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .step_mode(1'b0),
        .step(1'b0), .expected(exp_b), .vec_out(vec_b), .res_in(res_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .fail_valid(fv_b),
        .first_fail(ff_b), .table_out(table_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] tbl;
        logic        pass;
        logic        fv;
        logic [3:0]  ff;
        int          start_cyc;
        int          lat;        // negative: latency not checked
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];

    task automatic compare_result(input string tag, input exp_t e, input logic [15:0] tbl,
                                  input logic p, input logic fv, input logic [3:0] ff);
        check({tag, "_table"}, 32'(tbl), 32'(e.tbl));
        check({tag, "_pass"}, 32'(p), 32'(e.pass));
        check({tag, "_fail_valid"}, 32'(fv), 32'(e.fv));
        check({tag, "_first_fail"}, 32'(ff), 32'(e.ff));
        if (e.lat >= 0) check({tag, "_latency"}, 32'(cyc - e.start_cyc), 32'(e.lat));
    endtask

    // Monitor: compares on each rising edge of done, sampled on negedge.
    logic done_a_prev = 1'b0;
    logic done_b_prev = 1'b0;
    always @(negedge clk) begin
        if (done_a && !done_a_prev) begin
            if (sb_a.size() == 0) check("a_unexpected_done", 1, 0);
            else compare_result("a", sb_a.pop_front(), table_a, pass_a, fv_a, ff_a);
        end
        if (done_b && !done_b_prev) begin
            if (sb_b.size() == 0) check("b_unexpected_done", 1, 0);
            else compare_result("b", sb_b.pop_front(), table_b, pass_b, fv_b, ff_b);
        end
        done_a_prev <= done_a;
        done_b_prev <= done_b;
    end

    task automatic pulse_start_a();
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
    endtask

    // Issue an accepted start; returns just after the accepting edge.
    task automatic start_scan(input bit use_b, input logic [15:0] tbl, input logic p,
                              input logic fv, input logic [3:0] ff, input int lat, input bit track);
        exp_t e;
        @(negedge clk);
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        e.tbl = tbl; e.pass = p; e.fv = fv; e.ff = ff; e.start_cyc = cyc; e.lat = lat;
        if (track) begin
            if (use_b) sb_b.push_back(e); else sb_a.push_back(e);
        end
    endtask

    task automatic pulse_step_a();
        @(negedge clk); step_a = 1'b1;
        @(negedge clk); step_a = 1'b0;
    endtask

    task automatic wait_done(input bit use_b, input int budget);
        int n = 0;
        while (!(use_b ? done_b : done_a) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check(use_b ? "b_done_timeout" : "a_done_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; xor_mode = 1'b0;
        start_a = 1'b0; step_mode_a = 1'b0; step_a = 1'b0; exp_a = 16'h0;
        start_b = 1'b0; exp_b = 16'h0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_vec", 32'(vec_a), 0);
        check("rst_flags", {busy_a, done_a, pass_a, fv_a}, 0);
        check("rst_first_fail", 32'(ff_a), 0);
        check("rst_table", 32'(table_a), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // AND-4, all match, free-run: done 80 cycles after start
        xor_mode = 1'b0; exp_a = 16'h8000;
        start_scan(0, 16'h8000, 1'b1, 1'b0, 4'd0, 80, 1);
        check("and_busy_after_start", 32'(busy_a), 1);
        wait_done(0, 200);
        check("and_busy_cleared", 32'(busy_a), 0);
        check("and_vec_holds_last", 32'(vec_a), 15);

        // XOR-4 against table with bits 5 and 9 flipped
        xor_mode = 1'b1; exp_a = 16'h6BB6;
        start_scan(0, 16'h6996, 1'b0, 1'b1, 4'd5, 80, 1);
        repeat (22) @(negedge clk);
        check("xor_no_fail_yet", {fv_a, ff_a}, 0);
        repeat (12) @(negedge clk);
        check("xor_fail_latched", {fv_a, ff_a}, {1'b1, 4'd5});
        wait_done(0, 200);

        // Step mode with AND-4
        xor_mode = 1'b0; exp_a = 16'h8000; step_mode_a = 1'b1;
        start_scan(0, 16'h8000, 1'b1, 1'b0, 4'd0, -1, 1);
        repeat (5) @(negedge clk);
        pulse_step_a();
        check("step_1_vec", 32'(vec_a), 1);
        for (int s = 2; s <= 14; s++) begin
            repeat (8) @(negedge clk);
            pulse_step_a();
            check($sformatf("step_%0d_vec", s), 32'(vec_a), 32'(s));
            if (s == 3) begin
                pulse_step_a();
                check("step_in_settle_ignored", 32'(vec_a), 3);
            end
        end
        repeat (8) @(negedge clk);
        step_mode_a = 1'b0;
        repeat (10) @(negedge clk);
        check("step_mode_clear_holds", {done_a, vec_a}, {1'b0, 4'd14});
        pulse_step_a();
        check("step_15_vec", 32'(vec_a), 15);
        wait_done(0, 50);

        // Extra starts during a scan are ignored; timing unchanged
        xor_mode = 1'b1; exp_a = 16'h6996;
        start_scan(0, 16'h6996, 1'b1, 1'b0, 4'd0, 80, 1);
        repeat (8) @(negedge clk);
        pulse_start_a();
        repeat (28) @(negedge clk);
        pulse_start_a();
        check("extra_start_busy", 32'(busy_a), 1);
        wait_done(0, 200);

        // Start in DONE restarts with table cleared
        xor_mode = 1'b0; exp_a = 16'h8000;
        start_scan(0, 16'h8000, 1'b1, 1'b0, 4'd0, 80, 1);
        check("restart_table_cleared", 32'(table_a), 0);
        check("restart_flags", {busy_a, done_a, pass_a, vec_a}, {1'b1, 1'b0, 1'b0, 4'd0});
        wait_done(0, 200);

        // Reset mid-scan at vec_out=7
        start_scan(0, 16'h0, 1'b0, 1'b0, 4'd0, -1, 0);
        begin
            int n = 0;
            while (vec_a != 4'd7 && n < 100) begin @(negedge clk); n++; end
            if (n >= 100) check("reach_vec7_timeout", 0, 1);
        end
        rst_n = 1'b0;
        #1;
        check("midrst_vec", 32'(vec_a), 0);
        check("midrst_flags", {busy_a, done_a, pass_a, fv_a, ff_a}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_idle", {busy_a, done_a, vec_a}, 0);
        check("post_rst_table", 32'(table_a), 0);

        // SETTLE=1 build: done 32 cycles after start, same results as AND-4
        exp_b = 16'h8000;
        start_scan(1, 16'h8000, 1'b1, 1'b0, 4'd0, 32, 1);
        wait_done(1, 100);

        check("sb_a_drained", 32'(sb_a.size()), 0);
        check("sb_b_drained", 32'(sb_b.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
